// File: rtl/bound_link_vc_pkg.sv
// Shared constants for the target/interposer VC boundary link: flit type codes,
// header field positions, FIFO sizing and the enums used by both directions.
package bound_link_vc_pkg;

  localparam int BL_DW = 32;

  // Flit type lives in the top two bits; 2'b00 is the illegal encoding.
  typedef enum logic [1:0] {
    FLIT_ILLEGAL = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_BODY    = 2'b10,
    FLIT_TAIL    = 2'b11
  } flit_type_e;

  localparam int OUTBOUND_M = 29;
  localparam int RTDRID_HI  = 27;
  localparam int RTDRID_LO  = 24;
  localparam int ITPDRID_HI = 23;
  localparam int ITPDRID_LO = 20;
  localparam int DRID_HI    = 19;
  localparam int DRID_LO    = 16;

  localparam int BFIFO_DEPTH     = 4;
  localparam int BFIFO_DEPTH_LOG = 2;

  typedef enum logic {
    CHK_IDLE,
    CHK_IN_PKT
  } chk_state_e;

  typedef enum logic {
    REWRITE_T2I,
    REWRITE_I2T
  } rewrite_mode_e;

endpackage

// File: rtl/bound_link_vc_dir.sv
// One direction of the boundary link: per-VC FWFT FIFOs fed through a header
// rewrite and packet-order checker, drained by a round-robin VC arbiter.
module SyncFIFO_RTL #(
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0]        mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 push;
  logic                 pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

module bound_vc_dir
  import bound_link_vc_pkg::*;
#(
  parameter int DW         = BL_DW,
  parameter int NCH        = 2,
  parameter int VCW        = 1,
  parameter int DEPTH      = BFIFO_DEPTH,
  parameter int DEPTH_LOG  = BFIFO_DEPTH_LOG,
  parameter bit REWRITE_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  rewrite_mode_e mode,
  input  logic [DW-1:0] in_data,
  input  logic [VCW-1:0] in_vc,
  input  logic          in_valid,
  output logic [NCH-1:0] in_ready,
  output logic [DW-1:0] out_data,
  output logic [VCW-1:0] out_vc,
  output logic          out_valid,
  input  logic [NCH-1:0] out_ready,
  output logic [NCH-1:0] err
);

  flit_type_e     in_type;
  logic           accept;
  logic [DW-1:0]  wr_data;
  logic [NCH-1:0] wr_en;
  logic [NCH-1:0] rd_en;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] err_q;
  logic [NCH-1:0] err_d;
  logic [DW-1:0]  rd_data [NCH];
  chk_state_e     state_q [NCH];
  chk_state_e     state_d [NCH];
  logic [VCW-1:0] rr_q;
  logic [VCW-1:0] rr_d;
  logic [VCW-1:0] grant;
  logic [VCW-1:0] cand;
  logic           found;

  assign in_type  = flit_type_e'(in_data[DW-1:DW-2]);
  assign in_ready = ~full;
  assign accept   = in_valid && in_ready[in_vc];
  assign eligible = ~empty & out_ready;
  assign err      = err_q;

  always_comb begin
    wr_data = in_data;
    if (REWRITE_EN && in_type == FLIT_HEAD) begin
      if (mode == REWRITE_T2I) begin
        wr_data[OUTBOUND_M]          = 1'b0;
        wr_data[RTDRID_HI:RTDRID_LO] = in_data[ITPDRID_HI:ITPDRID_LO];
      end else begin
        wr_data[RTDRID_HI:RTDRID_LO] = in_data[DRID_HI:DRID_LO];
      end
    end
  end

  // Orphan BODY/TAIL and illegal flits are swallowed but still handshaken.
  always_comb begin
    wr_en = '0;
    err_d = err_q;
    for (int v = 0; v < NCH; v++) state_d[v] = state_q[v];
    for (int v = 0; v < NCH; v++) begin
      if (accept && in_vc == VCW'(v)) begin
        case (in_type)
          FLIT_HEAD: begin
            wr_en[v]   = 1'b1;
            if (state_q[v] == CHK_IN_PKT) err_d[v] = 1'b1;
            state_d[v] = CHK_IN_PKT;
          end
          FLIT_BODY, FLIT_TAIL: begin
            if (state_q[v] == CHK_IDLE) begin
              err_d[v] = 1'b1;
            end else begin
              wr_en[v] = 1'b1;
              if (in_type == FLIT_TAIL) state_d[v] = CHK_IDLE;
            end
          end
          default: err_d[v] = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    rd_en = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = VCW'((int'(rr_q) + k) % NCH);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    if (found) rd_en[grant] = 1'b1;
    rr_d = found ? VCW'((int'(grant) + 1) % NCH) : rr_q;
  end

  assign out_valid = found;
  assign out_vc    = grant;
  assign out_data  = rd_data[grant];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q  <= '0;
      err_q <= '0;
      for (int v = 0; v < NCH; v++) state_q[v] <= CHK_IDLE;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
      for (int v = 0; v < NCH; v++) state_q[v] <= state_d[v];
    end
  end

  for (genvar v = 0; v < NCH; v++) begin : g_vc
    SyncFIFO_RTL #(
      .DW(DW), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en[v]),
      .wr_data (wr_data),
      .rd_en   (rd_en[v]),
      .rd_data (rd_data[v]),
      .full    (full[v]),
      .empty   (empty[v])
    );
  end

endmodule

// File: rtl/bound_link_vc.sv
// Target/interposer boundary link with NCH virtual channels per direction;
// each direction is an independent bound_vc_dir with its own rewrite rule.
module bound_link_vc
  import bound_link_vc_pkg::*;
#(
  parameter int DW         = BL_DW,
  parameter int NCH        = 2,
  parameter int VCW        = 1,
  parameter int DEPTH      = BFIFO_DEPTH,
  parameter int DEPTH_LOG  = BFIFO_DEPTH_LOG,
  parameter bit REWRITE_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [DW-1:0]  trg_data_i,
  input  logic [VCW-1:0] trg_vc_i,
  input  logic           trg_valid_i,
  output logic [NCH-1:0] trg_ready_o,
  output logic [DW-1:0]  itp_data_o,
  output logic [VCW-1:0] itp_vc_o,
  output logic           itp_valid_o,
  input  logic [NCH-1:0] itp_ready_i,
  input  logic [DW-1:0]  itp_data_i,
  input  logic [VCW-1:0] itp_vc_i,
  input  logic           itp_valid_i,
  output logic [NCH-1:0] itp_ready_o,
  output logic [DW-1:0]  trg_data_o,
  output logic [VCW-1:0] trg_vc_o,
  output logic           trg_valid_o,
  input  logic [NCH-1:0] trg_ready_i,
  output logic [NCH-1:0] t2i_err_o,
  output logic [NCH-1:0] i2t_err_o
);

  bound_vc_dir #(
    .DW(DW), .NCH(NCH), .VCW(VCW), .DEPTH(DEPTH),
    .DEPTH_LOG(DEPTH_LOG), .REWRITE_EN(REWRITE_EN)
  ) u_t2i (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (REWRITE_T2I),
    .in_data   (trg_data_i),
    .in_vc     (trg_vc_i),
    .in_valid  (trg_valid_i),
    .in_ready  (trg_ready_o),
    .out_data  (itp_data_o),
    .out_vc    (itp_vc_o),
    .out_valid (itp_valid_o),
    .out_ready (itp_ready_i),
    .err       (t2i_err_o)
  );

  bound_vc_dir #(
    .DW(DW), .NCH(NCH), .VCW(VCW), .DEPTH(DEPTH),
    .DEPTH_LOG(DEPTH_LOG), .REWRITE_EN(REWRITE_EN)
  ) u_i2t (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (REWRITE_I2T),
    .in_data   (itp_data_i),
    .in_vc     (itp_vc_i),
    .in_valid  (itp_valid_i),
    .in_ready  (itp_ready_o),
    .out_data  (trg_data_o),
    .out_vc    (trg_vc_o),
    .out_valid (trg_valid_o),
    .out_ready (trg_ready_i),
    .err       (i2t_err_o)
  );

endmodule

// File: tb/tb_bound_link_vc.sv
// Scoreboard bench for bound_link_vc: expected flits are queued per direction
// and VC when driven, and checked as the DUT hands them downstream.
module tb_bound_link_vc;
  import bound_link_vc_pkg::*;

  localparam int DW  = BL_DW;
  localparam int NCH = 2;
  localparam int VCW = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]  trg_data_i, itp_data_o, itp_data_i, trg_data_o;
  logic [VCW-1:0] trg_vc_i, itp_vc_o, itp_vc_i, trg_vc_o;
  logic           trg_valid_i, itp_valid_o, itp_valid_i, trg_valid_o;
  logic [NCH-1:0] trg_ready_o, itp_ready_i, itp_ready_o, trg_ready_i;
  logic [NCH-1:0] t2i_err_o, i2t_err_o;

  logic           nr_en;
  logic           nr_itp_valid;
  logic [NCH-1:0] nr_trg_ready_o, nr_itp_ready_o, nr_t2i_err, nr_i2t_err;
  logic [DW-1:0]  nr_itp_data_o, nr_trg_data_o;
  logic [VCW-1:0] nr_itp_vc_o, nr_trg_vc_o;
  logic           nr_itp_valid_o, nr_trg_valid_o;

  assign nr_itp_valid = itp_valid_i & nr_en;

  bound_link_vc dut (
    .clk(clk), .rstn(rstn),
    .trg_data_i(trg_data_i), .trg_vc_i(trg_vc_i), .trg_valid_i(trg_valid_i),
    .trg_ready_o(trg_ready_o),
    .itp_data_o(itp_data_o), .itp_vc_o(itp_vc_o), .itp_valid_o(itp_valid_o),
    .itp_ready_i(itp_ready_i),
    .itp_data_i(itp_data_i), .itp_vc_i(itp_vc_i), .itp_valid_i(itp_valid_i),
    .itp_ready_o(itp_ready_o),
    .trg_data_o(trg_data_o), .trg_vc_o(trg_vc_o), .trg_valid_o(trg_valid_o),
    .trg_ready_i(trg_ready_i),
    .t2i_err_o(t2i_err_o), .i2t_err_o(i2t_err_o)
  );

  bound_link_vc #(.REWRITE_EN(1'b0)) dut_nr (
    .clk(clk), .rstn(rstn),
    .trg_data_i(trg_data_i), .trg_vc_i(trg_vc_i), .trg_valid_i(1'b0),
    .trg_ready_o(nr_trg_ready_o),
    .itp_data_o(nr_itp_data_o), .itp_vc_o(nr_itp_vc_o), .itp_valid_o(nr_itp_valid_o),
    .itp_ready_i(2'b11),
    .itp_data_i(itp_data_i), .itp_vc_i(itp_vc_i), .itp_valid_i(nr_itp_valid),
    .itp_ready_o(nr_itp_ready_o),
    .trg_data_o(nr_trg_data_o), .trg_vc_o(nr_trg_vc_o), .trg_valid_o(nr_trg_valid_o),
    .trg_ready_i(2'b11),
    .t2i_err_o(nr_t2i_err), .i2t_err_o(nr_i2t_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] t2i_q0[$], t2i_q1[$], i2t_q0[$], i2t_q1[$];
  logic [DW-1:0] nr_log[$];
  int            t2i_vc_log[$], t2i_time_log[$], i2t_vc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] make_flit(input logic [1:0] ty, input logic ob,
                                              input logic [3:0] rt, input logic [3:0] itp,
                                              input logic [3:0] dr, input logic [15:0] pay);
    return {ty, ob, 1'b0, rt, itp, dr, pay};
  endfunction

  // Downstream monitors: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (itp_valid_o && itp_ready_i[itp_vc_o]) begin
        t2i_vc_log.push_back(int'(itp_vc_o));
        t2i_time_log.push_back(cyc + 1);
        if (itp_vc_o == 1'b0) begin
          checkOutput("t2i_vc0_pending", 64'(t2i_q0.size() > 0), 64'd1);
          if (t2i_q0.size() > 0) checkOutput("t2i_vc0_data", itp_data_o, t2i_q0.pop_front());
        end else begin
          checkOutput("t2i_vc1_pending", 64'(t2i_q1.size() > 0), 64'd1);
          if (t2i_q1.size() > 0) checkOutput("t2i_vc1_data", itp_data_o, t2i_q1.pop_front());
        end
      end
      if (trg_valid_o && trg_ready_i[trg_vc_o]) begin
        i2t_vc_log.push_back(int'(trg_vc_o));
        if (trg_vc_o == 1'b0) begin
          checkOutput("i2t_vc0_pending", 64'(i2t_q0.size() > 0), 64'd1);
          if (i2t_q0.size() > 0) checkOutput("i2t_vc0_data", trg_data_o, i2t_q0.pop_front());
        end else begin
          checkOutput("i2t_vc1_pending", 64'(i2t_q1.size() > 0), 64'd1);
          if (i2t_q1.size() > 0) checkOutput("i2t_vc1_data", trg_data_o, i2t_q1.pop_front());
        end
      end
      if (nr_trg_valid_o) nr_log.push_back(nr_trg_data_o);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit dir, input logic [VCW-1:0] vc,
                               input logic [DW-1:0] flit, input bit written,
                               input logic [DW-1:0] expected);
    int  t;
    bit  ok;
    t = 0;
    if (dir == 1'b0) begin
      trg_data_i = flit; trg_vc_i = vc; trg_valid_i = 1'b1;
    end else begin
      itp_data_i = flit; itp_vc_i = vc; itp_valid_i = 1'b1;
    end
    if (written) begin
      case ({dir, vc})
        2'b00:   t2i_q0.push_back(expected);
        2'b01:   t2i_q1.push_back(expected);
        2'b10:   i2t_q0.push_back(expected);
        default: i2t_q1.push_back(expected);
      endcase
    end
    @(negedge clk);
    ok = (dir == 1'b0) ? trg_ready_o[vc] : itp_ready_o[vc];
    while (!ok && t < 100) begin
      @(negedge clk);
      t++;
      ok = (dir == 1'b0) ? trg_ready_o[vc] : itp_ready_o[vc];
    end
    checkOutput("accept_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    trg_valid_i = 1'b0;
    itp_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((t2i_q0.size() + t2i_q1.size() + i2t_q0.size() + i2t_q1.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput({tag, "_drain"}, 64'(t < 200), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    t2i_vc_log.delete();
    t2i_time_log.delete();
    i2t_vc_log.delete();
    nr_log.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] f;
    int            acc;

    trg_data_i = '0; trg_vc_i = '0; trg_valid_i = 1'b0;
    itp_data_i = '0; itp_vc_i = '0; itp_valid_i = 1'b0;
    itp_ready_i = 2'b11; trg_ready_i = 2'b11; nr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("rst_itp_valid", itp_valid_o, 0);
    checkOutput("rst_trg_valid", trg_valid_o, 0);
    checkOutput("rst_trg_ready", trg_ready_o, 2'b11);
    checkOutput("rst_itp_ready", itp_ready_o, 2'b11);
    checkOutput("rst_t2i_err", t2i_err_o, 0);
    checkOutput("rst_i2t_err", i2t_err_o, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // 3-flit packet on VC1 with HEAD rewrite and back-to-back latency.
    clear_logs();
    applyStimulus(0, 1'b1, make_flit(FLIT_HEAD, 1'b1, 4'hA, 4'h5, 4'h7, 16'h1234), 1,
                  make_flit(FLIT_HEAD, 1'b0, 4'h5, 4'h5, 4'h7, 16'h1234));
    acc = cyc;
    f = make_flit(FLIT_BODY, 1'b1, 4'hA, 4'h5, 4'h7, 16'hBEEF);
    applyStimulus(0, 1'b1, f, 1, f);
    f = make_flit(FLIT_TAIL, 1'b1, 4'hA, 4'h5, 4'h7, 16'hCAFE);
    applyStimulus(0, 1'b1, f, 1, f);
    wait_drain("pkt1");
    checkOutput("pkt1_count", t2i_vc_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("pkt1_vc", t2i_vc_log[i], 1);
      checkOutput("pkt1_cycle", t2i_time_log[i], acc + 1 + i);
    end
    checkOutput("pkt1_err", t2i_err_o, 0);

    // Interposer HEAD rewrite; the REWRITE_EN=0 instance passes it unchanged.
    clear_logs();
    nr_en = 1'b1;
    f = make_flit(FLIT_HEAD, 1'b1, 4'hC, 4'h9, 4'h3, 16'h0042);
    applyStimulus(1, 1'b0, f, 1, make_flit(FLIT_HEAD, 1'b1, 4'h3, 4'h9, 4'h3, 16'h0042));
    nr_en = 1'b0;
    applyStimulus(1, 1'b0, make_flit(FLIT_TAIL, 1'b0, 4'h1, 4'h2, 4'h3, 16'h0043), 1,
                  make_flit(FLIT_TAIL, 1'b0, 4'h1, 4'h2, 4'h3, 16'h0043));
    wait_drain("i2t");
    checkOutput("nr_count", nr_log.size(), 1);
    checkOutput("nr_head", nr_log[0], f);
    checkOutput("i2t_err", i2t_err_o, 0);

    // Two full VCs released together must interleave 0,1,0,1,...
    clear_logs();
    itp_ready_i = 2'b00;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 4; i++) begin
        f = make_flit((i == 0) ? FLIT_HEAD : ((i == 3) ? FLIT_TAIL : FLIT_BODY),
                      1'b0, 4'h0, 4'h0, 4'h0, 16'(16'h100 * v + i));
        applyStimulus(0, VCW'(v), f, 1, f);
      end
    end
    checkOutput("both_full_ready", trg_ready_o, 2'b00);
    itp_ready_i = 2'b11;
    wait_drain("rr");
    checkOutput("rr_count", t2i_vc_log.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("rr_order", t2i_vc_log[i], i % 2);

    // VC0 blocked downstream fills up while VC1 keeps flowing.
    clear_logs();
    itp_ready_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      f = make_flit((i == 0) ? FLIT_HEAD : FLIT_BODY, 1'b0, 4'h0, 4'h0, 4'h0, 16'(16'h200 + i));
      applyStimulus(0, 1'b0, f, 1, f);
    end
    f = make_flit(FLIT_HEAD, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0300);
    applyStimulus(0, 1'b1, f, 1, f);
    f = make_flit(FLIT_TAIL, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0301);
    applyStimulus(0, 1'b1, f, 1, f);
    repeat (3) @(negedge clk);
    checkOutput("bp_ready", trg_ready_o, 2'b10);
    checkOutput("bp_vc1_flowed", t2i_vc_log.size(), 2);
    checkOutput("bp_vc0_held", t2i_q0.size(), 4);
    @(posedge clk);
    #1;
    itp_ready_i = 2'b11;
    f = make_flit(FLIT_TAIL, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0204);
    applyStimulus(0, 1'b0, f, 1, f);
    wait_drain("bp");
    checkOutput("bp_ready_after", trg_ready_o, 2'b11);

    // Orphan BODY is dropped; duplicate HEAD is forwarded but flagged.
    clear_logs();
    applyStimulus(0, 1'b1, make_flit(FLIT_BODY, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0400), 0, '0);
    repeat (4) @(negedge clk);
    checkOutput("orphan_err", t2i_err_o, 2'b10);
    checkOutput("orphan_dropped", t2i_vc_log.size(), 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, make_flit(FLIT_HEAD, 1'b0, 4'h2, 4'h6, 4'h0, 16'h0500), 1,
                  make_flit(FLIT_HEAD, 1'b0, 4'h6, 4'h6, 4'h0, 16'h0500));
    applyStimulus(0, 1'b0, make_flit(FLIT_HEAD, 1'b1, 4'h2, 4'h8, 4'h0, 16'h0501), 1,
                  make_flit(FLIT_HEAD, 1'b0, 4'h8, 4'h8, 4'h0, 16'h0501));
    wait_drain("dup");
    checkOutput("dup_count", t2i_vc_log.size(), 2);
    checkOutput("dup_err", t2i_err_o, 2'b11);
    applyStimulus(1, 1'b1, make_flit(FLIT_ILLEGAL, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0600), 0, '0);
    repeat (4) @(negedge clk);
    checkOutput("illegal_err", i2t_err_o, 2'b10);
    checkOutput("illegal_dropped", i2t_vc_log.size(), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset with two flits buffered on VC0.
    clear_logs();
    itp_ready_i = 2'b00;
    f = make_flit(FLIT_BODY, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0700);
    applyStimulus(0, 1'b0, f, 1, f);
    f = make_flit(FLIT_BODY, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0701);
    applyStimulus(0, 1'b0, f, 1, f);
    @(negedge clk);
    #1;
    itp_ready_i = 2'b01;
    #1;
    checkOutput("prerst_valid", itp_valid_o, 1);
    #1;
    rstn = 1'b0;
    t2i_q0.delete();
    #1;
    checkOutput("arst_valid", itp_valid_o, 0);
    checkOutput("arst_trg_ready", trg_ready_o, 2'b11);
    checkOutput("arst_t2i_err", t2i_err_o, 0);
    checkOutput("arst_i2t_err", i2t_err_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("no_stale", t2i_vc_log.size(), 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, make_flit(FLIT_BODY, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0800), 0, '0);
    repeat (3) @(negedge clk);
    checkOutput("post_rst_orphan_err", t2i_err_o, 2'b01);
    checkOutput("post_rst_dropped", t2i_vc_log.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bound_link_vc.md
Name: bound_link_vc

Overview:
- Parametrised successor of the target/interposer boundary link; connects one target-NoC port to one interposer-NoC port.
- Each direction carries NCH virtual channels over one physical link: data, valid and a VC-id sideband, with per-VC ready.
- Each direction has one FIFO per VC, a header-rewrite stage, a per-VC packet-order checker and a round-robin output arbiter.

Parameters:
- DW, `DW: flit width; header field positions come from params.vh macros.
- NCH, 2: VCs per direction; must be >=2.
- VCW, 1: VC id width; equals log2(NCH), caller-supplied.
- DEPTH, `BFIFO_DEPTH: per-VC FIFO depth.
- DEPTH_LOG, `BFIFO_DEPTH_LOG: log2(DEPTH).
- REWRITE_EN, 1: 1 enables header rewrite; 0 passes flits unmodified.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- trg_data_i  in  DW  flit from target NoC.
- trg_vc_i  in  VCW  VC of trg_data_i.
- trg_valid_i  in  1  flit valid.
- trg_ready_o  out  NCH  per-VC space available.
- itp_data_o  out  DW  flit to interposer.
- itp_vc_o  out  VCW  VC of itp_data_o.
- itp_valid_o  out  1  flit valid.
- itp_ready_i  in  NCH  per-VC downstream ready.
- itp_data_i, itp_vc_i, itp_valid_i, itp_ready_o: interposer-side input, same shapes as the trg_* inputs.
- trg_data_o, trg_vc_o, trg_valid_o, trg_ready_i: target-side output, same shapes as the itp_* outputs.
- t2i_err_o  out  NCH  sticky per-VC packet-order error, target-to-interposer direction.
- i2t_err_o  out  NCH  sticky per-VC packet-order error, interposer-to-target direction.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous active-low: all FIFOs empty, checkers IDLE, round-robin pointers 0, err outputs 0.
- Reset values of outputs: valid_o 0; ready_o all 1; data_o and vc_o don't-care.
- Flit type: bits [DW-1:DW-2], codes HEAD, BODY, TAIL from params.vh. The fourth encoding is illegal.
- Input accept: a flit is accepted when valid_i && ready_o[vc_i]. ready_o[v] = ~full[v], registered FIFO state only. It never depends on valid_i.
- Rewrite, target-to-interposer, HEAD only and only when REWRITE_EN:
  - clear OUTBOUND_M;
  - RTDRID field <= ITPDRID field;
  - all other bits unchanged.
- Rewrite, interposer-to-target, HEAD only and only when REWRITE_EN:
  - RTDRID field <= DRID field.
- Non-HEAD flits are never modified.
- Per-VC checker, states IDLE and IN_PKT, evaluated on accepted flits:
  - IDLE + HEAD -> IN_PKT, flit written.
  - IN_PKT + BODY -> stay, written.
  - IN_PKT + TAIL -> IDLE, written.
  - IDLE + BODY/TAIL -> dropped (not written), err[v] set.
  - IN_PKT + HEAD -> written, stays IN_PKT, err[v] set.
  - Illegal type -> dropped, state unchanged, err[v] set.
  - Dropped flits still complete the handshake (ready was high).
- Output arbitration, each cycle:
  - Eligible set E = {v : FIFO[v] non-empty && ready_i[v]}.
  - Grant g = first v in E at or after pointer rr, searching cyclically.
  - valid_o = |E; data_o = head of FIFO[g]; vc_o = g.
  - The transfer occurs on that edge; FIFO[g] pops; rr <= (g+1) mod NCH.
  - No transfer leaves rr unchanged.
  - Downstream ready_i must not depend on valid_o.
  - VCs interleave flit by flit; order within a VC is preserved.
- Latency: FWFT FIFOs. A flit accepted at edge N is visible at the output in cycle N+1, at the earliest.
- Throughput: one flit per cycle per direction.
- Full FIFO: ready_o[v] = 0 and other VCs are unaffected. Push and pop on a full FIFO in the same cycle is not possible, since ready is already low.
- Empty FIFO: push and pop in the same cycle are not simultaneous; the pushed flit appears next cycle.
- Wrap-around: FIFO pointers wrap mod DEPTH. The rr pointer wraps NCH-1 -> 0.
- Reset mid-packet: all buffered flits are discarded and checkers return to IDLE. A later BODY/TAIL on that VC is flagged.
- err bits are cleared only by reset.

Decomposition:
- params.vh holds DW, the HEAD/BODY/TAIL codes, OUTBOUND_M, RTDRID/ITPDRID/DRID field bounds and BFIFO_DEPTH(_LOG). No new constants are defined locally.
- Sub-module bound_vc_dir holds one direction: NCH SyncFIFO_RTL (FWFT), checkers, rr arbiter and a mode input selecting the rewrite rule. It is instantiated twice.

Test Plan:
- Reset, then a 3-flit packet on VC1 target side (HEAD with OUTBOUND_M=1, ITPDRID=0x5), then BODY, TAIL -> itp_vc_o=1 on 3 consecutive cycles from N+1. HEAD has OUTBOUND_M=0 and RTDRID=0x5; BODY and TAIL are bit-identical.
- Interposer HEAD with DRID=0x3 on VC0 -> trg_data_o RTDRID=0x3; with REWRITE_EN=0 the flit is unchanged.
- VC0 and VC1 both loaded with 4 flits, all itp_ready_i high -> output vc sequence 0,1,0,1,0,1,0,1.
- itp_ready_i[0]=0 -> only VC1 flits flow; VC0 fills to DEPTH, then trg_ready_o[0]=0 while trg_ready_o[1]=1.
- BODY on an IDLE VC1 -> flit not output, t2i_err_o=2'b10. HEAD twice on VC0 -> both output, t2i_err_o[0]=1.
- Reset asserted asynchronously mid-packet with 2 flits buffered -> outputs return to reset values immediately. No stale flits are emitted after release.
